gate_result_serializer: RTL and testbench

GATE_RESULT_SERIALIZER -- requirements
Module: gate_result_serializer

---
 rtl/gate_result_serializer.sv | 143 ++++++++++++++
 tb/tb_gate_result_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_result_serializer.sv
// rtl/gate_result_serializer.sv - four-word gate result frame serializer (optional zero skipping via SER_ZERO_SKIP_EN)
module gate_result_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_and,
    input  logic [WIDTH-1:0] in_or,
    input  logic [WIDTH-1:0] in_not,
    input  logic [WIDTH-1:0] in_nand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             out_last
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] words [4];
    logic [3:0]       mask;
    logic [1:0]       idx;
    logic [1:0]       last_idx;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [WIDTH-1:0] out_data_r;

    logic [WIDTH-1:0] in_words [4];
    logic [3:0]       in_mask;
    logic [1:0]       in_first;
    logic [1:0]       in_last;
    logic [1:0]       cur_next;

    // Lowest set index in m at or above from (from may be 4 when nothing remains).
    function automatic logic [1:0] next_set(input logic [3:0] m, input logic [2:0] from);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) r = i[1:0];
        end
        return r;
    endfunction

    // Highest set index in m.
    function automatic logic [1:0] last_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = i[1:0];
        end
        return r;
    endfunction

    assign in_words[0] = in_and;
    assign in_words[1] = in_or;
    assign in_words[2] = in_not;
    assign in_words[3] = in_nand;

    // Marks which incoming words are to be sent.
    always_comb begin
        in_mask = 4'hF;
`ifdef SER_ZERO_SKIP_EN
        for (int i = 0; i < 4; i++) begin
            in_mask[i] = |in_words[i];
        end
`else
        in_mask = 4'hF;
`endif
    end

    // Index selection for the incoming frame and the captured frame.
    always_comb begin
        in_first = next_set(in_mask, 3'd0);
        in_last  = last_set(in_mask);
        cur_next = next_set(mask, {1'b0, idx} + 3'd1);
    end

    // Frame capture and word sequencing; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 2'd0;
            last_idx    <= 2'd0;
            mask        <= 4'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            for (int i = 0; i < 4; i++) begin
                words[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_ready_r && in_valid && (|in_mask)) begin
                        for (int i = 0; i < 4; i++) begin
                            words[i] <= in_words[i];
                        end
                        mask        <= in_mask;
                        last_idx    <= in_last;
                        idx         <= in_first;
                        out_data_r  <= in_words[in_first];
                        out_last_r  <= (in_first == in_last);
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last_r) begin
                            state       <= IDLE;
                            idx         <= 2'd0;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            out_data_r  <= '0;
                            in_ready_r  <= 1'b1;
                        end else begin
                            idx        <= cur_next;
                            out_data_r <= words[cur_next];
                            out_last_r <= (cur_next == last_idx);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = idx;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_gate_result_serializer.sv
// tb/tb_gate_result_serializer.sv - directed scoreboard bench for gate_result_serializer
module tb_gate_result_serializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_and, in_or, in_not, in_nand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_last;

    int checks   = 0;
    int failures = 0;

    logic [10:0] expq [$];
    logic [10:0] exp_item;

    gate_result_serializer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_and   (in_and),
        .in_or    (in_or),
        .in_not   (in_not),
        .in_nand  (in_nand),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Model: push the words the serializer must emit for this frame.
    task automatic push_frame(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] w [4];
        logic [3:0] m;
        int         last;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        last = -1;
        for (int i = 0; i < 4; i++) begin
`ifdef SER_ZERO_SKIP_EN
            m[i] = (w[i] != 8'h00);
`else
            m[i] = 1'b1;
`endif
            if (m[i]) last = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (m[i]) expq.push_back({(i == last), 2'(i), w[i]});
        end
    endtask

    task automatic drive_frame(input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input logic [7:0] w3);
        in_and = w0; in_or = w1; in_not = w2; in_nand = w3;
    endtask

    // Compare any transfer at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_word", 32'd1, 32'd0);
            end else begin
                exp_item = expq.pop_front();
                check("word", {21'd0, out_last, out_sel, out_data}, {21'd0, exp_item});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 12) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(expq.size()), 32'd0);
        tick();
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_frame(8'h00, 8'h00, 8'h00, 8'h00);
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_sel", {30'd0, out_sel}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Single frame, out_ready held high: four consecutive transfers.
        out_ready = 1'b1;
        drive_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        push_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat1_valid", {31'd0, out_valid}, 32'd1);
        check("send_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("consec_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        check("single_done", 32'(expq.size()), 32'd0);
        check("single_idle", {31'd0, out_valid}, 32'd0);
        tick();

        // Backpressure on sel=1.
        drive_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        push_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_sel", {30'd0, out_sel}, 32'd1);
            check("bp_data", {24'd0, out_data}, 32'h3F);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        drain();

        // Inputs ignored during SEND.
        out_ready = 1'b0;
        drive_frame(8'h11, 8'h22, 8'h33, 8'h44);
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_frame(8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i), 8'(8'hD0 + i));
            tick();
            check("ign_in_ready", {31'd0, in_ready}, 32'd0);
            check("ign_data", {24'd0, out_data}, 32'h11);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset mid-frame after sel=1 has transferred.
        drive_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        push_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        expq.delete();
        rst_n = 1'b1;
        tick();
        check("midrst_rearm", {31'd0, in_ready}, 32'd1);
        drive_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        push_frame(8'h0C, 8'h3F, 8'hF0, 8'hF3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("restart_sel", {30'd0, out_sel}, 32'd0);
        drain();

        // Frame with zero words.
        drive_frame(8'h00, 8'h55, 8'h00, 8'hAA);
        push_frame(8'h00, 8'h55, 8'h00, 8'hAA);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef SER_ZERO_SKIP_EN
        check("skip_first_sel", {30'd0, out_sel}, 32'd1);
`else
        check("noskip_first_sel", {30'd0, out_sel}, 32'd0);
`endif
        drain();

        // All-zero frame.
        drive_frame(8'h00, 8'h00, 8'h00, 8'h00);
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef SER_ZERO_SKIP_EN
        for (int i = 0; i < 3; i++) begin
            check("zero_valid", {31'd0, out_valid}, 32'd0);
            check("zero_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        check("zero_queue", 32'(expq.size()), 32'd0);
`else
        check("allzero_valid", {31'd0, out_valid}, 32'd1);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
